pkt_tx_encoder: RTL and testbench

- Transmit-side counterpart of the node-info/packet-decode path.
- Takes a send request from the node controller, snapshots the local node fields and serialises one packet as a stream of 16-bit words on a valid/ready link to the radio/MAC.
- Heartbeat (000) and CH-announce (001) packets start immediately.
- Data (101) packets wait for the node's own TDMA timeslot, tracked by an internal slot counter.

---
 rtl/eer_pkt_pkg.sv | 43 ++++
 rtl/pkt_tx_encoder_if.sv | 31 +++
 rtl/tdma_slot_counter.sv | 35 +++
 rtl/pkt_tx_encoder.sv | 228 ++++++++++++++++++++++
 tb/tb_pkt_tx_encoder.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eer_pkt_pkg.sv
// -----------------------------------------------------------------------------
// eer_pkt_pkg
// Shared packet definitions for the node-info encode/decode paths:
//   - packet type codes (3-bit type field of the header word)
//   - packet lengths in 16-bit words, header included
//   - fixed header words as they appear on the link
//   - encoder FSM state enum
// -----------------------------------------------------------------------------
package eer_pkt_pkg;

    localparam logic [2:0] PKT_HB   = 3'b000;
    localparam logic [2:0] PKT_CH   = 3'b001;
    localparam logic [2:0] PKT_TS   = 3'b100;
    localparam logic [2:0] PKT_DATA = 3'b101;

    localparam logic [2:0] LEN_HB   = 3'd6;
    localparam logic [2:0] LEN_CH   = 3'd4;
    localparam logic [2:0] LEN_DATA = 3'd5;

    // HB and DATA headers follow the {type, len, 8'h00} packing. The CH
    // header is the fixed 16'h0400 the decoder expects, not the generic packing.
    localparam logic [15:0] HDR_HB   = 16'h0600;
    localparam logic [15:0] HDR_CH   = 16'h0400;
    localparam logic [15:0] HDR_DATA = 16'hA500;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_SEND      = 2'd2
    } state_t;

    // Packet length in words for a (valid) packet type.
    function automatic logic [2:0] pkt_len(input logic [2:0] pkt_type);
        logic [2:0] len;
        case (pkt_type)
            PKT_HB:  len = LEN_HB;
            PKT_CH:  len = LEN_CH;
            default: len = LEN_DATA;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/pkt_tx_encoder_if.sv
// -----------------------------------------------------------------------------
// pkt_tx_encoder_if
// 16-bit valid/ready word stream from the packet encoder to the radio/MAC.
//   tx_word  : stream data          (master -> slave)
//   tx_valid : word valid           (master -> slave)
//   tx_last  : final word of packet (master -> slave)
//   tx_ready : slave can accept     (slave  -> master)
// A word transfers on a clock edge where tx_valid && tx_ready.
// -----------------------------------------------------------------------------
interface pkt_tx_encoder_if;

    logic [15:0] tx_word;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;

    modport master (
        output tx_word,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_word,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );

endinterface

// File: rtl/tdma_slot_counter.sv
// -----------------------------------------------------------------------------
// tdma_slot_counter
// Tracks the current TDMA slot. Advances on each slot_tick pulse and wraps
// from FRAME_SLOTS-1 back to 0. Runs independently of any packet activity.
// Ports:
//   clk          : clock
//   nrst         : synchronous active-low reset (slot returns to 0)
//   i_slot_tick  : one-cycle pulse at each slot boundary
//   o_cur_slot   : current slot number
// -----------------------------------------------------------------------------
module tdma_slot_counter #(
    parameter int FRAME_SLOTS = 16,
    parameter int SLOT_W      = 5
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_slot_tick,
    output logic [SLOT_W-1:0] o_cur_slot
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_SLOTS - 1);

    logic [SLOT_W-1:0] r_cur_slot;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_cur_slot <= '0;
        end else if (i_slot_tick) begin
            r_cur_slot <= (r_cur_slot == LAST_SLOT) ? '0 : r_cur_slot + SLOT_W'(1);
        end
    end

    assign o_cur_slot = r_cur_slot;

endmodule

// File: rtl/pkt_tx_encoder.sv
// -----------------------------------------------------------------------------
// pkt_tx_encoder
// Accepts a send request, snapshots the local node fields and streams one
// packet of 16-bit words to the MAC. HB and CH packets start on the cycle
// after acceptance; DATA packets wait until the TDMA slot counter reaches the
// node's own timeslot.
// Ports:
//   clk, nrst              : clock, synchronous active-low reset
//   i_tx_req, i_tx_type    : send request and packet type (HB/CH/DATA)
//   i_my_node_id .. i_payload : node fields captured at acceptance
//   i_my_timeslot          : node's TDMA slot (low SLOT_W bits compared)
//   i_slot_tick            : slot boundary pulse
//   tx_if (master)         : word stream tx_word/tx_valid/tx_last/tx_ready
//   o_busy                 : high from acceptance until the final handshake
//   o_tx_done              : pulse the cycle after the final handshake
//   o_tx_err               : pulse the cycle after a rejected request
//   o_cur_slot             : current TDMA slot
// -----------------------------------------------------------------------------
module pkt_tx_encoder
    import eer_pkt_pkg::*;
#(
    parameter int FRAME_SLOTS = 16,
    parameter int SLOT_W      = 5
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 i_tx_req,
    input  logic [2:0]           i_tx_type,
    input  logic [15:0]          i_my_node_id,
    input  logic [15:0]          i_hops_from_sink,
    input  logic [15:0]          i_my_q_value,
    input  logic [15:0]          i_energy,
    input  logic [15:0]          i_e_max,
    input  logic [15:0]          i_e_min,
    input  logic [15:0]          i_e_threshold,
    input  logic [15:0]          i_dest_id,
    input  logic [15:0]          i_payload,
    input  logic [15:0]          i_my_timeslot,
    input  logic                 i_slot_tick,
    pkt_tx_encoder_if.master     tx_if,
    output logic                 o_busy,
    output logic                 o_tx_done,
    output logic                 o_tx_err,
    output logic [SLOT_W-1:0]    o_cur_slot
);

    state_t            r_state;
    state_t            w_next_state;

    logic [2:0]        r_type;
    logic [15:0]       r_src;
    logic [15:0]       r_hops;
    logic [15:0]       r_q_value;
    logic [15:0]       r_energy;
    logic [15:0]       r_e_max;
    logic [15:0]       r_e_min;
    logic [15:0]       r_e_th;
    logic [15:0]       r_dest;
    logic [15:0]       r_payload;
    logic [SLOT_W-1:0] r_slot;
    logic [2:0]        r_idx;
    logic              r_done;
    logic              r_err;

    logic [SLOT_W-1:0] w_cur_slot;
    logic              w_type_ok;
    logic              w_slot_ok;
    logic              w_idle_req;
    logic              w_accept;
    logic              w_reject;
    logic [2:0]        w_len;
    logic              w_last;
    logic              w_fire;
    logic [15:0]       w_word;

    tdma_slot_counter #(
        .FRAME_SLOTS (FRAME_SLOTS),
        .SLOT_W      (SLOT_W)
    ) u_slot_counter (
        .clk         (clk),
        .nrst        (nrst),
        .i_slot_tick (i_slot_tick),
        .o_cur_slot  (w_cur_slot)
    );

    // Requests are only looked at in IDLE; while busy they are dropped silently.
    assign w_type_ok  = (i_tx_type == PKT_HB) || (i_tx_type == PKT_CH) || (i_tx_type == PKT_DATA);
    // Full 16-bit compare so an out-of-range slot is caught even if its low bits alias.
    assign w_slot_ok  = (i_tx_type != PKT_DATA) || (i_my_timeslot < 16'(FRAME_SLOTS));
    assign w_idle_req = i_tx_req && (r_state == ST_IDLE);
    assign w_accept   = w_idle_req && w_type_ok && w_slot_ok;
    assign w_reject   = w_idle_req && !(w_type_ok && w_slot_ok);

    assign w_len  = pkt_len(r_type);
    assign w_last = (r_state == ST_SEND) && (r_idx == w_len - 3'd1);
    assign w_fire = (r_state == ST_SEND) && tx_if.tx_ready;

    // Word selection from the snapshot; only index changes move the output,
    // so the word is inherently stable while the MAC stalls.
    always_comb begin
        w_word = 16'h0000;
        if (r_state == ST_SEND) begin
            case (r_type)
                PKT_HB: begin
                    case (r_idx)
                        3'd0:    w_word = HDR_HB;
                        3'd1:    w_word = r_src;
                        3'd2:    w_word = r_hops;
                        3'd3:    w_word = r_e_max;
                        3'd4:    w_word = r_e_min;
                        3'd5:    w_word = r_e_th;
                        default: w_word = 16'h0000;
                    endcase
                end
                PKT_CH: begin
                    case (r_idx)
                        3'd0:    w_word = HDR_CH;
                        3'd1:    w_word = r_src;
                        3'd2:    w_word = r_energy;
                        3'd3:    w_word = r_q_value;
                        default: w_word = 16'h0000;
                    endcase
                end
                default: begin
                    case (r_idx)
                        3'd0:    w_word = HDR_DATA;
                        3'd1:    w_word = r_src;
                        3'd2:    w_word = r_dest;
                        3'd3:    w_word = r_hops;
                        3'd4:    w_word = r_payload;
                        default: w_word = 16'h0000;
                    endcase
                end
            endcase
        end
    end

    // FSM state register.
    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and stream outputs.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state   = r_state;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_last  = 1'b0;
        tx_if.tx_word  = 16'h0000;
        o_busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (i_tx_type == PKT_DATA) ? ST_WAIT_SLOT : ST_SEND;
                end
            end
            ST_WAIT_SLOT: begin
                o_busy = 1'b1;
                if (w_cur_slot == r_slot) begin
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                o_busy         = 1'b1;
                tx_if.tx_valid = 1'b1;
                tx_if.tx_last  = w_last;
                tx_if.tx_word  = w_word;
                if (w_fire && w_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Snapshot, word index and status pulses.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_type    <= 3'b000;
            r_src     <= 16'h0000;
            r_hops    <= 16'h0000;
            r_q_value <= 16'h0000;
            r_energy  <= 16'h0000;
            r_e_max   <= 16'h0000;
            r_e_min   <= 16'h0000;
            r_e_th    <= 16'h0000;
            r_dest    <= 16'h0000;
            r_payload <= 16'h0000;
            r_slot    <= '0;
            r_idx     <= 3'd0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_reject;
            if (w_accept) begin
                r_type    <= i_tx_type;
                r_src     <= i_my_node_id;
                r_hops    <= i_hops_from_sink;
                r_q_value <= i_my_q_value;
                r_energy  <= i_energy;
                r_e_max   <= i_e_max;
                r_e_min   <= i_e_min;
                r_e_th    <= i_e_threshold;
                r_dest    <= i_dest_id;
                r_payload <= i_payload;
                r_slot    <= i_my_timeslot[SLOT_W-1:0];
                r_idx     <= 3'd0;
            end else if (w_fire) begin
                if (w_last) begin
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end
        end
    end

    assign o_tx_done  = r_done;
    assign o_tx_err   = r_err;
    assign o_cur_slot = w_cur_slot;

endmodule

// File: tb/tb_pkt_tx_encoder.sv
// -----------------------------------------------------------------------------
// tb_pkt_tx_encoder
// Directed scoreboard bench for pkt_tx_encoder. Stimulus pushes the expected
// {last, word} sequence of each packet into a queue; a monitor on the falling
// edge pops and compares on every handshake and checks that stalled words hold.
// -----------------------------------------------------------------------------
module tb_pkt_tx_encoder;

    localparam int FRAME_SLOTS = 16;
    localparam int SLOT_W      = 5;

    logic              clk = 1'b0;
    logic              nrst;
    logic              tx_req;
    logic [2:0]        tx_type;
    logic [15:0]       my_node_id, hops_from_sink, my_q_value, energy;
    logic [15:0]       e_max, e_min, e_threshold, dest_id, payload, my_timeslot;
    logic              slot_tick;
    logic              busy, tx_done, tx_err;
    logic [SLOT_W-1:0] cur_slot;

    pkt_tx_encoder_if tx_if();

    pkt_tx_encoder #(
        .FRAME_SLOTS (FRAME_SLOTS),
        .SLOT_W      (SLOT_W)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .i_tx_req         (tx_req),
        .i_tx_type        (tx_type),
        .i_my_node_id     (my_node_id),
        .i_hops_from_sink (hops_from_sink),
        .i_my_q_value     (my_q_value),
        .i_energy         (energy),
        .i_e_max          (e_max),
        .i_e_min          (e_min),
        .i_e_threshold    (e_threshold),
        .i_dest_id        (dest_id),
        .i_payload        (payload),
        .i_my_timeslot    (my_timeslot),
        .i_slot_tick      (slot_tick),
        .tx_if            (tx_if),
        .o_busy           (busy),
        .o_tx_done        (tx_done),
        .o_tx_err         (tx_err),
        .o_cur_slot       (cur_slot)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [16:0] exp_q[$];
    int          n_hs    = 0;
    int          n_done  = 0;
    logic        held_valid = 1'b0;
    logic [16:0] held_word;
    logic [16:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (tx_done) n_done++;
        if (held_valid && tx_if.tx_valid)
            check("hold_stable", {15'd0, tx_if.tx_last, tx_if.tx_word}, {15'd0, held_word});
        held_valid = 1'b0;
        if (tx_if.tx_valid) begin
            if (tx_if.tx_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h, expected no word (t=%0t)",
                             {tx_if.tx_last, tx_if.tx_word}, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("word", {15'd0, tx_if.tx_last, tx_if.tx_word}, {15'd0, mon_exp});
                end
            end else begin
                held_valid = 1'b1;
                held_word  = {tx_if.tx_last, tx_if.tx_word};
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic last, input logic [15:0] w);
        exp_q.push_back({last, w});
    endtask

    task automatic set_fields();
        my_node_id     = 16'h000C;
        hops_from_sink = 16'h0003;
        e_max          = 16'h0100;
        e_min          = 16'h0010;
        e_threshold    = 16'h0020;
        energy         = 16'h0080;
        my_q_value     = 16'h1234;
        dest_id        = 16'h0005;
        payload        = 16'hBEEF;
        my_timeslot    = 16'd0;
    endtask

    task automatic push_hb();
        push_word(1'b0, 16'h0600);
        push_word(1'b0, 16'h000C);
        push_word(1'b0, 16'h0003);
        push_word(1'b0, 16'h0100);
        push_word(1'b0, 16'h0010);
        push_word(1'b1, 16'h0020);
    endtask

    task automatic push_ch();
        push_word(1'b0, 16'h0400);
        push_word(1'b0, 16'h000C);
        push_word(1'b0, 16'h0080);
        push_word(1'b1, 16'h1234);
    endtask

    task automatic request(input logic [2:0] t);
        tx_type = t;
        tx_req  = 1'b1;
        cyc();
        tx_req  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < max_cycles; k++) begin
            if (tx_done) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int done0;
        int n_early;
        int n_extra;

        nrst         = 1'b0;
        tx_req       = 1'b0;
        tx_type      = 3'b000;
        slot_tick    = 1'b0;
        tx_if.tx_ready = 1'b0;
        set_fields();
        cyc();
        cyc();

        // Reset state
        check("reset_outputs", {11'd0, tx_if.tx_valid, tx_if.tx_last, busy, tx_done, tx_err, tx_if.tx_word},
              32'd0);
        check("reset_cur_slot", {27'd0, cur_slot}, 32'd0);
        nrst = 1'b1;
        cyc();

        // HB, ready held high, exact timing
        tx_if.tx_ready = 1'b1;
        push_hb();
        request(3'b000);
        check("hb_first_valid", {31'd0, tx_if.tx_valid}, 32'd1);
        check("hb_first_word", {16'd0, tx_if.tx_word}, 32'h0600);
        check("hb_busy", {31'd0, busy}, 32'd1);
        // Inputs changing after acceptance must not reach the packet.
        my_node_id = 16'hFFFF;
        e_threshold = 16'hDEAD;
        repeat (6) cyc();
        check("hb_done_at_n7", {31'd0, tx_done}, 32'd1);
        check("hb_idle_after", {30'd0, tx_if.tx_valid, busy}, 32'd0);
        cyc();
        check("hb_done_pulse", {31'd0, tx_done}, 32'd0);
        check("hb_queue_empty", exp_q.size(), 32'd0);
        set_fields();

        // CH with ready pattern 1,0,0 repeating
        push_ch();
        hs0 = n_hs;
        request(3'b001);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (tx_done) begin
                    seen = 1'b1;
                    break;
                end
                tx_if.tx_ready = (k % 3 == 0);
                cyc();
            end
            check("ch_done", {31'd0, seen}, 32'd1);
        end
        check("ch_handshakes", n_hs - hs0, 32'd4);
        check("ch_queue_empty", exp_q.size(), 32'd0);
        tx_if.tx_ready = 1'b1;

        // DATA in slot 3, counter starting at 0
        check("data_start_slot", {27'd0, cur_slot}, 32'd0);
        push_word(1'b0, 16'hA500);
        push_word(1'b0, 16'h000C);
        push_word(1'b0, 16'h0005);
        push_word(1'b0, 16'h0003);
        push_word(1'b1, 16'hBEEF);
        my_timeslot = 16'd3;
        request(3'b101);
        n_early = 0;
        for (int i = 0; i < 3; i++) begin
            if (tx_if.tx_valid) n_early++;
            slot_tick = 1'b1;
            cyc();
            slot_tick = 1'b0;
            if (tx_if.tx_valid) n_early++;
            cyc();
        end
        check("data_no_early_valid", n_early, 32'd0);
        check("data_slot3", {27'd0, cur_slot}, 32'd3);
        check("data_first_word", {15'd0, tx_if.tx_valid, tx_if.tx_word}, {15'd0, 1'b1, 16'hA500});
        wait_done("data_done", 20);
        check("data_queue_empty", exp_q.size(), 32'd0);

        // DATA slot 1 requested in slot 2: waits across the 15->0 wrap
        nrst = 1'b0;
        cyc();
        nrst = 1'b1;
        slot_tick = 1'b1;
        cyc();
        cyc();
        slot_tick = 1'b0;
        check("wrap_start_slot", {27'd0, cur_slot}, 32'd2);
        dest_id = 16'h0007;
        payload = 16'h5A5A;
        my_timeslot = 16'd1;
        push_word(1'b0, 16'hA500);
        push_word(1'b0, 16'h000C);
        push_word(1'b0, 16'h0007);
        push_word(1'b0, 16'h0003);
        push_word(1'b1, 16'h5A5A);
        request(3'b101);
        n_early = 0;
        slot_tick = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (tx_if.tx_valid) n_early++;
            if (i == 13) check("wrap_slot15", {27'd0, cur_slot}, 32'd15);
            if (i == 14) check("wrap_slot0", {27'd0, cur_slot}, 32'd0);
            cyc();
        end
        slot_tick = 1'b0;
        check("wrap_no_early_valid", n_early, 32'd0);
        check("wrap_slot1_wait", {27'd0, cur_slot, tx_if.tx_valid}, {27'd0, 5'd1, 1'b0});
        cyc();
        check("wrap_first_word", {15'd0, tx_if.tx_valid, tx_if.tx_word}, {15'd0, 1'b1, 16'hA500});
        wait_done("wrap_done", 20);
        set_fields();

        // Rejected: illegal type
        request(3'b011);
        check("rej_type_err", {29'd0, tx_err, busy, tx_if.tx_valid}, {29'd0, 3'b100});
        cyc();
        check("rej_type_after", {29'd0, tx_err, busy, tx_if.tx_valid}, 32'd0);

        // Rejected: DATA slot out of range
        my_timeslot = 16'd16;
        request(3'b101);
        check("rej_slot_err", {29'd0, tx_err, busy, tx_if.tx_valid}, {29'd0, 3'b100});
        cyc();
        check("rej_slot_after", {29'd0, tx_err, busy, tx_if.tx_valid}, 32'd0);
        set_fields();

        // Ignored: request while busy
        push_hb();
        request(3'b000);
        cyc();
        request(3'b001);
        check("busy_req_ignored", {30'd0, tx_err, busy}, {30'd0, 2'b01});
        wait_done("busy_hb_done", 20);
        n_extra = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (tx_if.tx_valid) n_extra++;
        end
        check("busy_no_queued_pkt", n_extra, 32'd0);

        // Reset in the middle of an HB
        slot_tick = 1'b1;
        cyc();
        slot_tick = 1'b0;
        push_hb();
        request(3'b000);
        cyc();
        nrst = 1'b0;
        tx_if.tx_ready = 1'b0;
        done0 = n_done;
        cyc();
        check("midrst_outputs", {11'd0, tx_if.tx_valid, tx_if.tx_last, busy, tx_done, tx_err, tx_if.tx_word},
              32'd0);
        check("midrst_cur_slot", {27'd0, cur_slot}, 32'd0);
        exp_q.delete();
        nrst = 1'b1;
        tx_if.tx_ready = 1'b1;
        repeat (4) cyc();
        check("midrst_no_done", n_done - done0, 32'd0);

        // Fresh CH after reset
        push_ch();
        hs0 = n_hs;
        request(3'b001);
        wait_done("post_rst_ch_done", 20);
        check("post_rst_ch_hs", n_hs - hs0, 32'd4);
        check("post_rst_queue_empty", exp_q.size(), 32'd0);

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
